// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the front end.
// Holds the fetch-buffer entry layout, default depth and the canonical NOP encoding.
package uarch_pkg;

  localparam int CPU_ADDR_BITS    = 32;
  localparam int CPU_INST_BITS    = 32;
  localparam int FB_DEPTH_DEFAULT = 8;

  // ADDI x0,x0,0
  localparam logic [CPU_INST_BITS-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] inst;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: 2-wide circular queue between fetch and decode, presenting instruction pairs.
// Optional macro FB_SINGLE_PAD_EN lets a lone instruction issue paired with a NOP.
module fetch_buffer
  import uarch_pkg::*;
#(
  parameter int FB_DEPTH = FB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_val0,
  input  logic                     fetch_val1,
  input  logic [CPU_ADDR_BITS-1:0] fetch_pc0,
  input  logic [CPU_ADDR_BITS-1:0] fetch_pc1,
  input  logic [CPU_INST_BITS-1:0] fetch_inst0,
  input  logic [CPU_INST_BITS-1:0] fetch_inst1,
  output logic                     fetch_rdy,
  input  logic                     decode_rdy,
  output logic [CPU_ADDR_BITS-1:0] inst0_pc,
  output logic [CPU_ADDR_BITS-1:0] inst1_pc,
  output logic [CPU_INST_BITS-1:0] inst0,
  output logic [CPU_INST_BITS-1:0] inst1,
  output logic                     inst_val
);

  localparam int PTR_W = $clog2(FB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FB_DEPTH);

`ifdef FB_SINGLE_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  fb_entry_t        mem_q [FB_DEPTH];
  fb_entry_t        ent0, ent1;
  logic             pad_case;
  logic             enq, deq;
  logic [1:0]       enq_n, deq_n;
  logic             wr0_en, wr1_en;

  always_comb begin
    head_nxt = head_q + PTR_W'(1);
    tail_nxt = tail_q + PTR_W'(1);
    ent0     = mem_q[head_q];
    ent1     = mem_q[head_nxt];
    pad_case = PAD_EN && (count_q == CNT_W'(1));

    // fetch_rdy looks only at the current count; a same-cycle dequeue is not credited
    fetch_rdy = rst && (count_q <= DEPTH_CNT - CNT_W'(2));
    inst_val  = rst && !flush && ((count_q >= CNT_W'(2)) || pad_case);

    inst0_pc = ent0.pc;
    inst0    = ent0.inst;
    if (pad_case) begin
      inst1_pc = ent0.pc + CPU_ADDR_BITS'(4);
      inst1    = NOP_INST;
    end else begin
      inst1_pc = ent1.pc;
      inst1    = ent1.inst;
    end

    enq   = fetch_val0 && fetch_rdy;
    deq   = inst_val && decode_rdy;
    enq_n = enq ? (fetch_val1 ? 2'd2 : 2'd1) : 2'd0;
    deq_n = deq ? (pad_case ? 2'd1 : 2'd2) : 2'd0;

    wr0_en = enq && !flush;
    wr1_en = wr0_en && fetch_val1;

    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);

    // flush drops any enqueue/dequeue that coincides with it
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[tail_q] <= fb_entry_t'{pc: fetch_pc0, inst: fetch_inst0};
    end
    if (wr1_en) begin
      mem_q[tail_nxt] <= fb_entry_t'{pc: fetch_pc1, inst: fetch_inst1};
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed + randomized bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
`ifdef FB_SINGLE_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk;
  logic        rst, flush;
  logic        fv0, fv1;
  logic [31:0] pc0, pc1, i0, i1;
  logic        fetch_rdy, drdy;
  logic [31:0] inst0_pc, inst1_pc, inst0, inst1;
  logic        inst_val;

  int checks = 0;
  int passed = 0;

  logic [63:0] mq [$];
  bit          m_rdy;

  fetch_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fetch_val0 (fv0),
    .fetch_val1 (fv1),
    .fetch_pc0  (pc0),
    .fetch_pc1  (pc1),
    .fetch_inst0(i0),
    .fetch_inst1(i1),
    .fetch_rdy  (fetch_rdy),
    .decode_rdy (drdy),
    .inst0_pc   (inst0_pc),
    .inst1_pc   (inst1_pc),
    .inst0      (inst0),
    .inst1      (inst1),
    .inst_val   (inst_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fetch2(input logic [31:0] pc);
    fv0 = 1'b1; fv1 = 1'b1; pc0 = pc; pc1 = pc + 32'd4;
    i0 = $urandom; i1 = $urandom;
  endtask

  task automatic set_fetch1(input logic [31:0] pc);
    fv0 = 1'b1; fv1 = 1'b0; pc0 = pc; pc1 = 32'd0;
    i0 = $urandom; i1 = 32'd0;
  endtask

  task automatic clear_fetch();
    fv0 = 1'b0; fv1 = 1'b0;
  endtask

  // One clock: compare outputs against the model's pre-edge view, then advance the model.
  task automatic step();
    bit          er, ev;
    int          n;
    logic [63:0] ent;
    logic [31:0] e0pc, e0, e1pc, e1;
    #1;
    er = rst && ((DEPTH - mq.size()) >= 2);
    ev = rst && !flush && ((mq.size() >= 2) || (PAD_EN && mq.size() == 1));
    chk("fetch_rdy", {31'd0, fetch_rdy}, {31'd0, er});
    chk("inst_val", {31'd0, inst_val}, {31'd0, ev});
    if (ev) begin
      ent = mq[0];
      e0pc = ent[63:32]; e0 = ent[31:0];
      if (mq.size() >= 2) begin
        ent = mq[1];
        e1pc = ent[63:32]; e1 = ent[31:0];
      end else begin
        e1pc = e0pc + 32'd4; e1 = 32'h00000013;
      end
      chk("inst0_pc", inst0_pc, e0pc);
      chk("inst0", inst0, e0);
      chk("inst1_pc", inst1_pc, e1pc);
      chk("inst1", inst1, e1);
    end
    m_rdy = er;
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (ev && drdy) begin
        n = (mq.size() >= 2) ? 2 : 1;
        repeat (n) void'(mq.pop_front());
      end
      if (fv0 && er) begin
        mq.push_back({pc0, i0});
        if (fv1) mq.push_back({pc1, i1});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] next_pc;
    bit          holding;

    rst = 1'b0; flush = 1'b0; drdy = 1'b0;
    fv0 = 1'b0; fv1 = 1'b0; pc0 = '0; pc1 = '0; i0 = '0; i1 = '0;
    m_rdy = 1'b0;
    @(negedge clk);

    // held in reset: both handshakes low
    step(); step();
    rst = 1'b1;
    step();

    // first pair flows through with one cycle of latency
    drdy = 1'b1;
    set_fetch2(32'h100);
    step();
    clear_fetch();
    #1;
    chk("first_pair_val", {31'd0, inst_val}, 32'd1);
    chk("first_pair_pc0", inst0_pc, 32'h100);
    chk("first_pair_pc1", inst1_pc, 32'h104);
    step();
    step();

    // fill to FB_DEPTH with decode stalled; 5th pair must be held off
    drdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_fetch2(32'h100 + 32'(8 * k));
      step();
    end
    set_fetch2(32'h120);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_rdy", {31'd0, fetch_rdy}, 32'd0);
      chk("full_hold_pc", inst0_pc, 32'h100);
      step();
    end
    drdy = 1'b1;
    step(); step();
    clear_fetch();
    repeat (6) step();

    // lone instruction
    set_fetch1(32'h200);
    step();
    clear_fetch();
    #1;
    if (PAD_EN) begin
      chk("pad_val", {31'd0, inst_val}, 32'd1);
      chk("pad_pc0", inst0_pc, 32'h200);
      chk("pad_inst1", inst1, 32'h00000013);
      chk("pad_pc1", inst1_pc, 32'h204);
    end else begin
      chk("lone_val", {31'd0, inst_val}, 32'd0);
    end
    step();
    flush = 1'b1; step(); flush = 1'b0;
    step();

    // flush at count 6 with a coincident fetch and decode_rdy
    drdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_fetch2(32'h300 + 32'(8 * k));
      step();
    end
    drdy = 1'b1; flush = 1'b1;
    set_fetch2(32'h318);
    step();
    flush = 1'b0; clear_fetch();
    #1;
    chk("flush_val", {31'd0, inst_val}, 32'd0);
    chk("flush_rdy", {31'd0, fetch_rdy}, 32'd1);
    step();

    // steady state 2-in/2-out, wrapping the pointers many times
    drdy = 1'b1;
    next_pc = 32'h1000;
    for (int k = 0; k < 22; k++) begin
      set_fetch2(next_pc);
      next_pc = next_pc + 32'd8;
      step();
      if (k >= 2) begin
        #1;
        chk("steady_rdy", {31'd0, fetch_rdy}, 32'd1);
        chk("steady_seq", inst1_pc, inst0_pc + 32'd4);
      end
    end
    clear_fetch();
    step(); step();

    // odd occupancy so later pairs straddle the wrap point, then mid-stream reset at count 5
    drdy = 1'b0;
    set_fetch2(32'h400); step();
    set_fetch2(32'h408); step();
    set_fetch1(32'h410); step();
    rst = 1'b0;
    set_fetch2(32'h414);
    step();
    #1;
    chk("rst_val", {31'd0, inst_val}, 32'd0);
    chk("rst_rdy", {31'd0, fetch_rdy}, 32'd0);
    rst = 1'b1; clear_fetch();
    #1;
    chk("rel_val", {31'd0, inst_val}, 32'd0);
    chk("rel_rdy", {31'd0, fetch_rdy}, 32'd1);
    step();

    // randomized traffic with fetch holding its group until accepted
    next_pc = 32'h8000;
    holding = 1'b0;
    for (int k = 0; k < 500; k++) begin
      rst   = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 29) == 0);
      drdy  = ($urandom_range(0, 2) != 0);
      if (!holding) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) != 0) set_fetch2(next_pc);
          else set_fetch1(next_pc);
        end else begin
          clear_fetch();
        end
      end
      step();
      if (fv0 && m_rdy) begin
        next_pc = next_pc + (fv1 ? 32'd8 : 32'd4);
        holding = 1'b0;
      end else begin
        holding = fv0;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter FB_DEPTH, default 8, number of single-instruction entries; SHALL be a power of two and at least 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; rst=0 sampled at a rising clk edge resets the block.
REQ-004 flush  input  1  active-high; discards all buffered instructions.
REQ-005 fetch_val0, fetch_val1  input  1 each  fetch slot valid; fetch_val1=1 only with fetch_val0=1.
REQ-006 fetch_pc0, fetch_pc1  input  CPU_ADDR_BITS each  PCs of the fetch slots.
REQ-007 fetch_inst0, fetch_inst1  input  CPU_INST_BITS each  instruction words of the fetch slots.
REQ-008 fetch_rdy  output  1  buffer can accept a 2-instruction fetch group this cycle.
REQ-009 decode_rdy  input  1  decode accepts the presented pair this cycle.
REQ-010 inst0_pc, inst1_pc  output  CPU_ADDR_BITS each  PCs of the presented pair; inst0 is older.
REQ-011 inst0, inst1  output  CPU_INST_BITS each  presented instruction pair.
REQ-012 inst_val  output  1  single valid bit covering both inst0 and inst1.

Function
REQ-013 Storage SHALL be a circular queue of FB_DEPTH {pc, inst} entries with head/tail pointers of clog2(FB_DEPTH) bits that wrap modulo FB_DEPTH, plus an occupancy count of clog2(FB_DEPTH)+1 bits.
REQ-014 fetch_rdy SHALL be 1 iff rst=1 and free entries (FB_DEPTH - count) >= 2; it depends on the current count only and does not credit a dequeue in the same cycle.
REQ-015 Enqueue fires when fetch_val0 && fetch_rdy: slot 0 is written at tail, slot 1 at tail+1 if fetch_val1, and tail advances by 1 or 2.
REQ-016 Fetch inputs presented while fetch_rdy=0 SHALL be ignored; fetch holds them.
REQ-017 inst0/inst0_pc SHALL come combinationally from entry head, and inst1/inst1_pc from entry head+1 (wrapping).
REQ-018 inst_val SHALL be 1 iff rst=1, flush=0 and count >= 2 (see REQ-027 for the count==1 case).
REQ-019 Dequeue fires when inst_val && decode_rdy: head advances by 2 (1 in the padded case of REQ-027).
REQ-020 Enqueue and dequeue in the same cycle SHALL both take effect; count_next = count + enq_n - deq_n.
REQ-021 Latency: an instruction enqueued at edge N is presentable from cycle N+1; there is no bypass from fetch to decode.
REQ-022 Outputs SHALL hold stable while inst_val=1 and decode_rdy=0.
REQ-023 When flush=1, head, tail and count SHALL clear to 0 at the next edge; a simultaneous enqueue or dequeue is dropped.
REQ-024 Program order SHALL be preserved across pointer wrap-around, including a pair that straddles entry FB_DEPTH-1 and entry 0.

Reset
REQ-025 With rst=0 at an edge, head=0, tail=0 and count=0 (rst takes priority over flush and enqueue); entry contents need not be cleared.
REQ-026 While rst=0: inst_val=0 and fetch_rdy=0. After release: inst_val=0 and fetch_rdy=1 until the first enqueue.

Configuration
REQ-027 With FB_SINGLE_PAD_EN defined and count==1, inst_val=1, inst0 is the head entry, inst1=32'h00000013 (ADDI x0,x0,0), inst1_pc=inst0_pc+4, and dequeue advances head by 1.
REQ-028 Without FB_SINGLE_PAD_EN, count==1 gives inst_val=0; the lone instruction waits for a partner or a flush.

Structure
REQ-029 uarch_pkg SHALL hold the fb_entry_t typedef {pc, inst}, FB_DEPTH_DEFAULT=8 and NOP_INST=32'h00000013; CPU_ADDR_BITS/CPU_INST_BITS are taken from uarch_pkg.
REQ-030 Single module, no sub-module; pointer, count and storage logic are inline.

Verification
REQ-031 Reset release, then a 2-wide fetch {pc 0x100,0x104} with decode_rdy=1 -> inst_val=1 the next cycle with inst0_pc=0x100 and inst1_pc=0x104; count returns to 0 after dequeue.
REQ-032 decode_rdy=0 with 4 pairs pushed (FB_DEPTH=8) -> fetch_rdy=0 at count=8; a 5th pair is held and not written, and outputs stay on pc 0x100 until decode_rdy=1.
REQ-033 Steady state: enqueue 2 and dequeue 2 every cycle for 20 cycles -> count constant and PCs strictly sequential across pointer wrap.
REQ-034 Single fetch of pc 0x200 -> inst_val=0 without FB_SINGLE_PAD_EN; with it, inst0_pc=0x200, inst1=0x00000013, inst1_pc=0x204.
REQ-035 flush asserted together with fetch_val0=1 and a dequeue at count=6 -> next cycle count=0, inst_val=0 and fetch_rdy=1.
REQ-036 rst=0 asserted mid-stream at count=5 -> next cycle inst_val=0 and fetch_rdy=0; after release, inst_val=0 and fetch_rdy=1.
